// File: rtl/mix_columns_seq.sv
// mix_columns_seq
//   Sequential AES MixColumns. A 128-bit state word is accepted with a
//   valid/ready handshake. One column is processed per cycle over four BUSY
//   cycles, and the result is then held until downstream takes it.
//   Setting bypass passes the state through unmixed, for the final round.
//
// Ports
//   i_clk     clock; all state updates on the rising edge
//   i_rst_n   asynchronous active-low reset
//   i_valid   upstream offers i_state/i_bypass
//   o_ready   block can accept a word (IDLE only)
//   i_state   AES state; column c = bits [127-32c : 96-32c], row 0 = MSB
//   i_bypass  1 = copy the state unchanged
//   o_valid   o_state holds a completed result (DONE only)
//   i_ready   downstream accepts the result
//   o_state   mixed state, same byte layout as i_state

module mix_columns_seq (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [127:0] i_state,
    input  logic         i_bypass,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [127:0] o_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_e;

    fsm_e         fsm_q, fsm_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [127:0] cap_q, cap_d;
    logic         bypass_q, bypass_d;
    logic [127:0] out_q, out_d;

    logic [31:0]  col_in;
    logic [31:0]  col_out;

    // GF(2^8) multiply by 2. The reduction term is applied when bit 7 of the
    // input was set, and the result is truncated to 8 bits.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul3(input logic [7:0] x);
        mul3 = xtime(x) ^ x;
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] r0, r1, r2, r3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        r0 = xtime(a0) ^ mul3(a1) ^ a2 ^ a3;
        r1 = a0 ^ xtime(a1) ^ mul3(a2) ^ a3;
        r2 = a0 ^ a1 ^ xtime(a2) ^ mul3(a3);
        r3 = mul3(a0) ^ a1 ^ a2 ^ xtime(a3);
        mix_column = {r0, r1, r2, r3};
    endfunction

    // Select the column addressed by cnt from the captured state.
    always_comb begin
        col_in = '0;
        case (cnt_q)
            2'd0: col_in = cap_q[127:96];
            2'd1: col_in = cap_q[95:64];
            2'd2: col_in = cap_q[63:32];
            2'd3: col_in = cap_q[31:0];
            default: col_in = '0;
        endcase
        col_out = bypass_q ? col_in : mix_column(col_in);
    end

    always_comb begin
        fsm_d    = fsm_q;
        cnt_d    = cnt_q;
        cap_d    = cap_q;
        bypass_d = bypass_q;
        out_d    = out_q;

        case (fsm_q)
            IDLE: begin
                if (i_valid) begin
                    cap_d    = i_state;
                    bypass_d = i_bypass;
                    cnt_d    = 2'd0;
                    fsm_d    = BUSY;
                end
            end

            BUSY: begin
                case (cnt_q)
                    2'd0: out_d[127:96] = col_out;
                    2'd1: out_d[95:64]  = col_out;
                    2'd2: out_d[63:32]  = col_out;
                    2'd3: out_d[31:0]   = col_out;
                    default: out_d = out_q;
                endcase
                // cnt wraps from 3 back to 0 on the final column.
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    fsm_d = DONE;
                end
            end

            DONE: begin
                if (i_ready) begin
                    fsm_d = IDLE;
                end
            end

            default: begin
                fsm_d = IDLE;
                cnt_d = 2'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fsm_q    <= IDLE;
            cnt_q    <= 2'd0;
            cap_q    <= '0;
            bypass_q <= 1'b0;
            out_q    <= '0;
        end else begin
            fsm_q    <= fsm_d;
            cnt_q    <= cnt_d;
            cap_q    <= cap_d;
            bypass_q <= bypass_d;
            out_q    <= out_d;
        end
    end

    assign o_ready = (fsm_q == IDLE);
    assign o_valid = (fsm_q == DONE);
    assign o_state = out_q;

endmodule
